asub_ise: RTL and testbench

Multi-cycle AES byte-substitution instruction-set extension for the HOKSTER core: computes the forward S-box or the inverse S-box of one byte per issued instruction. It sits directly downstream of the inverse-MixColumns ISE in the decryption round, consuming its output bytes after the software inverse ShiftRows. The forward mode serves encryption and key expansion. The S-box is computed arithmetically (GF(2^8) inversion by square-and-multiply) rather than from a 256-entry table, trading latency for area.

---
 rtl/asub_ise.sv | 174 +++++++++++++++++
 tb/tb_asub_ise.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/asub_ise.sv
`default_nettype none
// ============================================================================
//  Module   : asub_ise
//  Purpose  : Multi-cycle AES byte-substitution ISE. Computes the forward or
//             inverse S-box of one byte per instruction, using an arithmetic
//             GF(2^8) inversion (x^254 by square-and-multiply) that shares a
//             single combinational multiplier.
//  Revision : 1.0  initial release
// ============================================================================
module asub_ise (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic [7:0] sr,
    output logic [7:0] sr_out,
    output logic [7:0] result,
    output logic       wait_req
);

    // Low byte of the AES reduction polynomial 0x11B
    localparam logic [7:0] c_POLY     = 8'h1B;
    localparam logic [7:0] c_FWD_CONST = 8'h63;
    localparam logic [7:0] c_INV_CONST = 8'h05;
    // LMUL count value at which the sixth and final multiply happens
    localparam logic [2:0] c_LAST_ITER = 3'd5;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_SQ0  = 3'd1,
        S_LSQ  = 3'd2,
        S_LMUL = 3'd3,
        S_POST = 3'd4,
        S_DONE = 3'd5
    } state_t;

    state_t     r_state;
    state_t     w_next;
    logic [7:0] r_x;
    logic [7:0] r_t;
    logic [7:0] r_r;
    logic [2:0] r_cnt;
    logic       r_mode;
    logic [7:0] r_result;
    logic [7:0] w_mul_a;
    logic [7:0] w_mul_b;
    logic [7:0] w_mul_p;

    // Only b[0] carries meaning; the rest of the mode byte is ignored
    logic w_unused_b;
    assign w_unused_b = &{1'b0, b[7:1]};

    // Shift-and-add multiply in GF(2^8) mod 0x11B
    function automatic logic [7:0] gf_mul(input logic [7:0] p, input logic [7:0] q);
        logic [7:0] acc;
        logic [7:0] m;
        acc = 8'h00;
        m   = p;
        for (int i = 0; i < 8; i++) begin
            if (q[i]) acc = acc ^ m;
            m = {m[6:0], 1'b0} ^ (m[7] ? c_POLY : 8'h00);
        end
        return acc;
    endfunction

    // AES forward affine transform applied after inversion
    function automatic logic [7:0] fwd_affine(input logic [7:0] y);
        logic [7:0] o;
        for (int i = 0; i < 8; i++) begin
            o[i] = y[i] ^ y[(i + 4) % 8] ^ y[(i + 5) % 8] ^ y[(i + 6) % 8]
                 ^ y[(i + 7) % 8] ^ c_FWD_CONST[i];
        end
        return o;
    endfunction

    // AES inverse affine transform applied before inversion
    function automatic logic [7:0] inv_affine(input logic [7:0] x);
        logic [7:0] o;
        for (int i = 0; i < 8; i++) begin
            o[i] = x[(i + 2) % 8] ^ x[(i + 5) % 8] ^ x[(i + 7) % 8] ^ c_INV_CONST[i];
        end
        return o;
    endfunction

    // Operand select for the single shared multiplier: square x, square t, or r*t
    always_comb begin
        w_mul_a = r_r;
        w_mul_b = r_t;
        unique case (r_state)
            S_SQ0: begin
                w_mul_a = r_x;
                w_mul_b = r_x;
            end
            S_LSQ: begin
                w_mul_a = r_t;
                w_mul_b = r_t;
            end
            default: ;
        endcase
    end

    assign w_mul_p = gf_mul(w_mul_a, w_mul_b);

    // State register
    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    // Next-state logic; DONE ignores start since it is the still-held instruction
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: if (start) w_next = S_SQ0;
            S_SQ0:  w_next = S_LSQ;
            S_LSQ:  w_next = S_LMUL;
            S_LMUL: w_next = (r_cnt == c_LAST_ITER) ? S_POST : S_LSQ;
            S_POST: w_next = S_DONE;
            S_DONE: w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Datapath: operand capture, square/multiply chain and result write-back
    always_ff @(posedge clk) begin
        if (rst) begin
            r_x      <= 8'h00;
            r_t      <= 8'h00;
            r_r      <= 8'h00;
            r_cnt    <= 3'd0;
            r_mode   <= 1'b0;
            r_result <= 8'h00;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_x    <= b[0] ? a : inv_affine(a);
                        r_mode <= b[0];
                        r_cnt  <= 3'd0;
                    end
                end
                S_SQ0: begin
                    r_t <= w_mul_p;
                    r_r <= w_mul_p;
                end
                S_LSQ: r_t <= w_mul_p;
                S_LMUL: begin
                    r_r   <= w_mul_p;
                    r_cnt <= r_cnt + 3'd1;
                end
                S_POST: r_result <= r_mode ? fwd_affine(r_r) : r_r;
                default: ;
            endcase
        end
    end

    // Stall the core from the accepting IDLE cycle through POST
    always_comb begin
        wait_req = 1'b0;
        if (!rst) begin
            unique case (r_state)
                S_IDLE:                        wait_req = start;
                S_SQ0, S_LSQ, S_LMUL, S_POST:  wait_req = 1'b1;
                default:                       wait_req = 1'b0;
            endcase
        end
    end

    assign result = r_result;
    assign sr_out = sr;

endmodule
`default_nettype wire

// File: tb/tb_asub_ise.sv
`default_nettype none
// ============================================================================
//  Module   : tb_asub_ise
//  Purpose  : Self-checking bench for asub_ise: directed vector table,
//             reset corner cases, mid-operation input changes, a full
//             back-to-back sweep and random operations against a table model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_asub_ise;

    logic       clk;
    logic       rst;
    logic       start;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] sr;
    logic [7:0] sr_out;
    logic [7:0] result;
    logic       wait_req;

    int n_cmp;
    int n_err;

    logic [7:0] sbox_tab [256];
    logic [7:0] isbox_tab[256];
    logic [7:0] last_exp;

    typedef struct {
        logic [7:0] av;
        logic [7:0] bv;
        logic [7:0] exp;
        string      name;
    } vec_t;

    vec_t vecs[6];

    asub_ise dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .a        (a),
        .b        (b),
        .sr       (sr),
        .sr_out   (sr_out),
        .result   (result),
        .wait_req (wait_req)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: plain GF(2^8) product, inverse found by search, affine by rotations
    function automatic logic [7:0] ref_mul(input logic [7:0] p, input logic [7:0] q);
        int acc = 0;
        int pp  = p;
        for (int i = 0; i < 8; i++) begin
            if (q[i]) acc = acc ^ pp;
            pp = pp << 1;
            if (pp > 255) pp = pp ^ 'h11B;
        end
        return acc[7:0];
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] v, input int k);
        logic [15:0] d;
        d = {v, v} << k;
        return d[15:8];
    endfunction

    task automatic build_model();
        for (int x = 0; x < 256; x++) begin
            logic [7:0] inv;
            logic [7:0] s;
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (x != 0 && ref_mul(x[7:0], y[7:0]) == 8'h01) inv = y[7:0];
            s = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
            sbox_tab[x] = s;
            isbox_tab[s] = x[7:0];
        end
    endtask

    function automatic logic [7:0] model(input logic [7:0] av, input logic [7:0] bv);
        return bv[0] ? sbox_tab[av] : isbox_tab[av];
    endfunction

    // One instruction: advance a cycle to the IDLE accept, hold start, count stall cycles
    task automatic do_op(input logic [7:0] av, input logic [7:0] bv, input logic [7:0] exp,
                         input bit drop, input bit scramble, input string name);
        int  n;
        bit  held_bad;
        bit  sr_bad;
        @(posedge clk); #1;
        start = 1'b1;
        a = av;
        b = bv;
        n = 0;
        held_bad = 1'b0;
        sr_bad = 1'b0;
        while (wait_req && n < 40) begin
            if (result !== last_exp) held_bad = 1'b1;
            if (sr_out !== sr) sr_bad = 1'b1;
            n++;
            @(posedge clk); #1;
            sr = 8'($urandom);
            if (scramble && n >= 1 && n <= 14) begin
                a = 8'($urandom);
                b = 8'($urandom);
            end
        end
        chk({name, " stall cycles"}, n, 15);
        chk({name, " result"}, result, exp);
        chk({name, " held/sr ok"}, {30'd0, held_bad, sr_bad}, 0);
        last_exp = exp;
        if (drop) start = 1'b0;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        last_exp = 8'h00;
        rst = 1'b1;
        start = 1'b0;
        a = 8'h00;
        b = 8'h00;
        sr = 8'hA5;
        build_model();

        vecs[0] = '{8'h00, 8'h00, 8'h52, "inv00"};
        vecs[1] = '{8'h00, 8'h01, 8'h63, "fwd00"};
        vecs[2] = '{8'h01, 8'h01, 8'h7C, "fwd01"};
        vecs[3] = '{8'h53, 8'hFF, 8'hED, "fwd53"};
        vecs[4] = '{8'hED, 8'h00, 8'h53, "invED"};
        vecs[5] = '{8'h63, 8'hFE, 8'h00, "inv63_zero"};

        // Reset state, and start asserted together with rst latches nothing
        repeat (2) @(posedge clk);
        #1;
        chk("reset result", result, 8'h00);
        chk("reset wait_req", wait_req, 0);
        chk("reset sr_out", sr_out, 8'hA5);
        start = 1'b1;
        a = 8'h53;
        b = 8'h01;
        #1;
        chk("start+rst wait_req", wait_req, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        start = 1'b0;
        sr = 8'h3C;
        #1;
        chk("start+rst nothing latched", wait_req, 0);
        chk("sr_out follows", sr_out, 8'h3C);

        // Directed vectors
        for (int i = 0; i < 6; i++)
            do_op(vecs[i].av, vecs[i].bv, vecs[i].exp, 1'b1, 1'b0, vecs[i].name);

        // Mid-operation changes to a/b are ignored; previous result held until POST
        do_op(8'h01, 8'h01, 8'h7C, 1'b1, 1'b1, "scramble");

        // Reset in cycle 7 of an operation aborts it
        @(posedge clk); #1;
        start = 1'b1;
        a = 8'h53;
        b = 8'h01;
        repeat (7) begin
            @(posedge clk); #1;
        end
        chk("mid-op wait_req before rst", wait_req, 1);
        rst = 1'b1;
        #1;
        chk("wait_req during rst", wait_req, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        start = 1'b0;
        #1;
        chk("abort result cleared", result, 8'h00);
        chk("abort wait_req", wait_req, 0);
        last_exp = 8'h00;
        do_op(8'h53, 8'h01, 8'hED, 1'b1, 1'b0, "reissue");

        // Exhaustive sweep in both modes, start held continuously
        for (int m = 0; m < 2; m++)
            for (int v = 0; v < 256; v++)
                do_op(v[7:0], {7'h55, m[0]}, model(v[7:0], {7'h0, m[0]}), 1'b0, 1'b0,
                      $sformatf("sweep m%0d a%02h", m, v));
        start = 1'b0;

        // Random operations with random gaps and mid-op scrambling
        for (int k = 0; k < 40; k++) begin
            logic [7:0] ra;
            logic [7:0] rb;
            ra = 8'($urandom);
            rb = 8'($urandom);
            repeat ($urandom_range(0, 3)) @(posedge clk);
            do_op(ra, rb, model(ra, rb), 1'b1, k[0], $sformatf("rand%0d", k));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
